// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM encoding, bubble instruction, PC step and target alignment helper.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Redirect targets are word aligned by clearing the two low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage (master) and memory (slave).
// Handshake: req/addr are held until ack; ack and data are valid in the same cycle, one word per ack.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus and presents one
// instruction per cycle to IF/ID, with stall hold, branch/jump redirect and bubble insertion.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic [31:0]            branch_addr_i,
    input  logic                   jump_i,
    input  logic [31:0]            jump_addr_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instr_o,
    output logic [31:0]            pc_o,
    output logic [31:0]            pc_plus4_o,
    output logic                   fetch_valid_o,
    output fetch_state_e           dbg_state_o
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_drop_addr;
    logic [31:0]  r_buf_instr;
    logic [31:0]  r_buf_pc;
    logic         w_redirect;
    logic [31:0]  w_target;

    // Branch has priority over jump when both resolve in the same cycle.
    assign w_redirect  = branch_i | jump_i;
    assign w_target    = align_word(branch_i ? branch_addr_i : jump_addr_i);
    assign dbg_state_o = r_state;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = ST_REQ;
            ST_REQ: begin
                if (imem.ack) begin
                    w_next_state = w_redirect ? ST_REQ : ST_OUT;
                end else if (w_redirect) begin
                    w_next_state = ST_DROP;
                end
            end
            ST_OUT: begin
                if (w_redirect) begin
                    w_next_state = ST_REQ;
                end else if (!stall_i) begin
                    w_next_state = imem.ack ? ST_OUT : ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem.ack) begin
                    w_next_state = ST_REQ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        imem.req      = 1'b0;
        imem.addr     = 32'h0;
        fetch_valid_o = 1'b0;
        instr_o       = NOP_INSTR;
        pc_o          = 32'h0;
        pc_plus4_o    = 32'h0;
        case (r_state)
            ST_REQ: begin
                imem.req  = 1'b1;
                imem.addr = r_pc;
            end
            ST_OUT: begin
                fetch_valid_o = 1'b1;
                instr_o       = r_buf_instr;
                pc_o          = r_buf_pc;
                pc_plus4_o    = r_buf_pc + PC_STEP;
                // Prefetch the next word in the same cycle IF/ID consumes this one.
                if (!w_redirect && !stall_i) begin
                    imem.req  = 1'b1;
                    imem.addr = r_pc;
                end
            end
            ST_DROP: begin
                imem.req  = 1'b1;
                imem.addr = r_drop_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'h0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'h0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem.ack && !w_redirect) begin
                        r_buf_instr <= imem.data;
                        r_buf_pc    <= r_pc;
                        r_pc        <= r_pc + PC_STEP;
                    end else if (w_redirect) begin
                        // Without an ack the wrong-path request must still be completed from DROP.
                        if (!imem.ack) begin
                            r_drop_addr <= r_pc;
                        end
                        r_pc <= w_target;
                    end
                end
                ST_OUT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end else if (!stall_i && imem.ack) begin
                        r_buf_instr <= imem.data;
                        r_buf_pc    <= r_pc;
                        r_pc        <= r_pc + PC_STEP;
                    end
                end
                ST_DROP: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory returns ~addr, expected fetches and presented
// instructions are queued by the driver and popped by independent monitors.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         stall_i;
    logic         branch_i;
    logic [31:0]  branch_addr_i;
    logic         jump_i;
    logic [31:0]  jump_addr_i;
    logic         ack_on;
    logic [31:0]  instr_o;
    logic [31:0]  pc_o;
    logic [31:0]  pc_plus4_o;
    logic         fetch_valid_o;
    fetch_state_e dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] exp_q[$];
    logic [31:0] addr_q[$];

    always #5 clk = ~clk;

    if_fetch_unit_if imem ();

    assign imem.ack  = ack_on & imem.req;
    assign imem.data = ~imem.addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .imem          (imem),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .fetch_valid_o (fetch_valid_o),
        .dbg_state_o   (dbg_state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_instr(input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        exp_q.push_back({~pc, pc, p4});
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] ba,
                        input logic jp, input logic [31:0] ja, input logic ak);
        @(posedge clk);
        #1;
        stall_i       = st;
        branch_i      = br;
        branch_addr_i = ba;
        jump_i        = jp;
        jump_addr_i   = ja;
        ack_on        = ak;
    endtask

    // Every acknowledged fetch must match the next expected address.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_i && imem.req && imem.ack) begin
            if (addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_addr: unexpected fetch of %h, none expected", imem.addr);
            end else begin
                e = addr_q.pop_front();
                chk("req_addr", imem.addr, e);
            end
        end
    end

    // Every instruction consumed by IF/ID must match the next expected one.
    always @(negedge clk) begin
        logic [95:0] e;
        if (!rst_i && fetch_valid_o && !stall_i && !branch_i && !jump_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL instr: unexpected instruction %h pc %h, none expected", instr_o, pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("instr_o", instr_o, e[95:64]);
                chk("pc_o", pc_o, e[63:32]);
                chk("pc_plus4_o", pc_plus4_o, e[31:0]);
            end
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
        branch_addr_i = 32'h0; jump_addr_i = 32'h0; ack_on = 1'b0;

        // Reset, release, then re-assert reset in the middle of a pending request.
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(dbg_state_o), 32'(ST_IDLE));
        chk("idle_req", 32'(imem.req), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("first_req", 32'(imem.req), 32'd1);
        chk("first_addr", imem.addr, 32'h100);
        chk("first_bubble", instr_o, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("req_wait_state", 32'(dbg_state_o), 32'(ST_REQ));
        #2 rst_i = 1'b1;
        #1;
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc_plus4_o, 32'h0);
        chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));

        // Zero-wait memory: one instruction per cycle.
        @(posedge clk);
        #1 rst_i = 1'b0; ack_on = 1'b1;
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h100 + 32'(i * 4));
        for (int i = 0; i < 3; i++) push_instr(32'h100 + 32'(i * 4));
        @(negedge clk);
        chk("c0_req", 32'(imem.req), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("c1_valid", 32'(fetch_valid_o), 32'd0);
        chk("c1_instr", instr_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("stream_valid", 32'(fetch_valid_o), 32'd1);
        end

        // Stall for three cycles while 0x10C is presented.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("stall_req", 32'(imem.req), 32'd0);
            chk("stall_instr", instr_o, ~32'h10C);
            chk("stall_pc", pc_o, 32'h10C);
            chk("stall_valid", 32'(fetch_valid_o), 32'd1);
        end
        push_instr(32'h10C);
        addr_q.push_back(32'h110);
        step(0, 0, 0, 0, 0, 1);
        push_instr(32'h110);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("c9_addr", imem.addr, 32'h114);

        // Branch to unaligned 0x203 while 0x114 is outstanding; ack comes two cycles late.
        step(0, 1, 32'h203, 0, 0, 0);
        @(negedge clk);
        chk("br_addr", imem.addr, 32'h114);
        chk("br_valid", 32'(fetch_valid_o), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drop_state", 32'(dbg_state_o), 32'(ST_DROP));
        chk("drop_addr", imem.addr, 32'h114);
        chk("drop_valid", 32'(fetch_valid_o), 32'd0);
        addr_q.push_back(32'h114);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("drop_ack_valid", 32'(fetch_valid_o), 32'd0);
        addr_q.push_back(32'h200);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("target_addr", imem.addr, 32'h200);
        chk("target_valid", 32'(fetch_valid_o), 32'd0);

        // Branch and jump together during a stall: branch wins, redirect beats stall.
        step(1, 1, 32'h400, 1, 32'h800, 1);
        @(negedge clk);
        chk("both_req", 32'(imem.req), 32'd0);
        chk("both_instr", instr_o, ~32'h200);
        addr_q.push_back(32'h400);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("prio_addr", imem.addr, 32'h400);
        chk("prio_state", 32'(dbg_state_o), 32'(ST_REQ));
        push_instr(32'h400);
        step(0, 0, 0, 0, 0, 0);

        // Jump to the top word of the address space and wrap.
        step(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
        @(negedge clk);
        chk("jmp_addr", imem.addr, 32'h404);
        addr_q.push_back(32'h404);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("jmp_drop_state", 32'(dbg_state_o), 32'(ST_DROP));
        addr_q.push_back(32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1);
        push_instr(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("wrap_pc4", pc_plus4_o, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_next_pc4", pc_plus4_o, 32'h4);
        chk("wrap_instr", instr_o, 32'hFFFF_FFFF);

        step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("instr_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
